hazard_scoreboard: RTL and testbench

- Hazard-detection counterpart to the decode stage.
- Consumes the decode stage's source-register report (two-source flag, Rn, Rd/Rm) and its issued destination and control bits.
- Keeps its own shadow of the in-flight writers in the EX and MEM slots and returns the `hazard` stall request to decode and fetch.
- Also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_scoreboard.sv | 144 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard-detection companion to the decode stage. It keeps a private shadow
// of the instructions that decode has issued into the EX and MEM stages. Each
// cycle it compares their destinations against the source registers of the
// instruction now sitting in decode. When a consumer would read a value that
// is not yet available, it raises `hazard`. That signal stalls fetch, IF/ID
// and decode, and the scoreboard inserts a bubble into its own EX slot.
//
// A saturating counter, `stallCount`, records how many cycles were lost to
// stalls. It is for performance measurement only.
//
// Build option (macro HAZARD_FORWARDING_EN):
//   undefined : no forwarding datapath. Any in-flight writer in EX or MEM
//               blocks a dependent reader (2 stall cycles from EX, 1 from MEM).
//   defined   : the datapath forwards from MEM and WB. Only a load in EX
//               blocks a dependent reader (1 stall cycle, load-use).
//   Ports and counter behaviour are identical in both builds.
//
// Parameters:
//   CNT_W       width of the stall-cycle counter.
//
// Ports:
//   clk         clock; all state updates on the rising edge.
//   rst         asynchronous active-high reset.
//   idTwoSrc    decode instruction also reads idRdm.
//   idRn        first source register of the decode instruction.
//   idRdm       second source register (Rm, or Rd for stores).
//   idDest      destination register issued from decode.
//   idWbEn      decode instruction writes back (already condition-gated).
//   idMemRead   decode instruction is a load.
//   flush       taken branch; the decode-slot instruction is squashed.
//   clrStats    synchronous clear of stallCount.
//   hazard      stall request to fetch, IF/ID and decode (combinational).
//   stallCount  saturating count of cycles with hazard = 1.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idTwoSrc,
  input  logic [3:0]       idRn,
  input  logic [3:0]       idRdm,
  input  logic [3:0]       idDest,
  input  logic             idWbEn,
  input  logic             idMemRead,
  input  logic             flush,
  input  logic             clrStats,
  output logic             hazard,
  output logic [CNT_W-1:0] stallCount
);

  // One in-flight writer as decode saw it when it was issued.
  typedef struct packed {
    logic       valid;    // slot holds an instruction that writes back
    logic [3:0] dest;     // destination register (meaningless when !valid)
    logic       memRead;  // instruction is a load
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, dest: 4'd0, memRead: 1'b0};

  slot_t exSlot;
  slot_t memSlot;
  slot_t exNext;

  logic exMatch;
  logic memMatch;
  logic insertBubble;

  // True when the writer in `s` produces a register that the decode
  // instruction reads. R15 is compared like any other register; decode
  // handles PC reads before they ever reach this block.
  function automatic logic slotMatch(
    input slot_t      s,
    input logic       twoSrc,
    input logic [3:0] rn,
    input logic [3:0] rdm
  );
    return s.valid & ((s.dest == rn) | (twoSrc & (s.dest == rdm)));
  endfunction

  assign exMatch  = slotMatch(exSlot,  idTwoSrc, idRn, idRdm);
  assign memMatch = slotMatch(memSlot, idTwoSrc, idRn, idRdm);

  // There is no WB-slot check. The register file writes in the first half of
  // WB and decode reads in the same cycle, so a WB producer is already
  // visible to decode.
`ifdef HAZARD_FORWARDING_EN
  // MEM and WB results are forwarded. Only a load still in EX cannot
  // supply its data in time for the dependent instruction.
  assign hazard = exSlot.memRead & exMatch;
`else
  // No forwarding: any pending writer blocks the reader until it retires
  // past MEM.
  assign hazard = exMatch | memMatch;
`endif

  // A stall and a squash both turn the decode slot into a single bubble.
  // When both happen in the same cycle, only one bubble results.
  assign insertBubble = hazard | flush;

  // Writers are recorded by their write-back enable. An instruction that
  // does not write back is stored as a bubble. Its dest is still captured,
  // but it is never used because valid is 0.
  always_comb begin
    exNext = BUBBLE;
    if (!insertBubble) begin
      exNext.valid   = idWbEn;
      exNext.dest    = idDest;
      exNext.memRead = idMemRead;
    end
  end

  // Shadow pipeline. MEM always takes the old EX contents. A flush never
  // touches EX or MEM, because those instructions are older than the branch
  // and still complete. Bubbles are invalid, so repeated stalls always drain.
  // NOTE: state registers use non-blocking assignments so that memSlot
  // samples the pre-edge value of exSlot regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exSlot  <= BUBBLE;
      memSlot <= BUBBLE;
    end else begin
      memSlot <= exSlot;
      exSlot  <= exNext;
    end
  end

  // Stall-cycle counter. clrStats takes priority over counting. The counter
  // sticks at all ones instead of wrapping, so a long run never reads back
  // as a small number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (clrStats) begin
      stallCount <= '0;
    end else if (hazard && !(&stallCount)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. The counter is instantiated narrow
// (CNT_W = 4) so that saturation is reachable in a short run. Expected values
// are worked out by hand for both builds. The HAZARD_FORWARDING_EN macro
// selects which set applies.
//
// Timing: inputs change 2 time units after a rising edge. Combinational
// checks follow 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int CNT_W = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             idTwoSrc;
  logic [3:0]       idRn;
  logic [3:0]       idRdm;
  logic [3:0]       idDest;
  logic             idWbEn;
  logic             idMemRead;
  logic             flush;
  logic             clrStats;
  logic             hazard;
  logic [CNT_W-1:0] stallCount;

  int checkCount = 0;
  int errorCount = 0;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .idTwoSrc   (idTwoSrc),
    .idRn       (idRn),
    .idRdm      (idRdm),
    .idDest     (idDest),
    .idWbEn     (idWbEn),
    .idMemRead  (idMemRead),
    .flush      (flush),
    .clrStats   (clrStats),
    .hazard     (hazard),
    .stallCount (stallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock and land 2 units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic twoSrc, input logic [3:0] rn,
                       input logic [3:0] rdm, input logic [3:0] dest,
                       input logic wbEn, input logic memRead);
    idTwoSrc  = twoSrc;
    idRn      = rn;
    idRdm     = rdm;
    idDest    = dest;
    idWbEn    = wbEn;
    idMemRead = memRead;
  endtask

  task automatic idle();
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // Feed bubbles until both shadow slots are empty, then zero the counter.
  task automatic drainAndClear();
    idle();
    step();
    step();
    clrStats = 1'b1;
    step();
    clrStats = 1'b0;
  endtask

  initial begin
    idle();
    flush    = 1'b0;
    clrStats = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;

    // Reset state and idle bubbles.
    check("reset_hazard", hazard, 0);
    check("reset_count", stallCount, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_hazard", hazard, 0);
    end
    check("idle_count", stallCount, 0);

    // ALU writer r3, then a reader of r3.
    issue(1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    #1 check("raw_issue", hazard, 0);
    step();
    issue(1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 check("raw_ex", hazard, FWD ? 0 : 1);
    step();
    check("raw_mem", hazard, FWD ? 0 : 1);
    step();
    check("raw_release", hazard, 0);
    check("raw_count", stallCount, FWD ? 0 : 2);
    drainAndClear();
    check("clr_count", stallCount, 0);

    // Load r5, then a two-source reader using r5 as Rm.
    issue(1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    #1 step();
    issue(1'b1, 4'd1, 4'd5, 4'd0, 1'b0, 1'b0);
    #1 check("load_ex", hazard, 1);
    step();
    check("load_mem", hazard, FWD ? 0 : 1);
    step();
    check("load_release", hazard, 0);
    check("load_count", stallCount, FWD ? 1 : 2);
    drainAndClear();

    // Same pair, but the second source is not in use.
    issue(1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    #1 step();
    issue(1'b0, 4'd1, 4'd5, 4'd0, 1'b0, 1'b0);
    #1 check("onesrc_ex", hazard, 0);
    step();
    check("onesrc_mem", hazard, 0);
    drainAndClear();

    // Writer r4, then a flushed writer r7.
    issue(1'b0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    #1 step();
    issue(1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1 check("flush_cycle", hazard, 0);
    step();
    flush = 1'b0;
    issue(1'b0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 check("flushed_dest", hazard, 0);
    issue(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 check("older_in_mem", hazard, FWD ? 0 : 1);
    step();
    check("older_release", hazard, 0);
    check("flush_count", stallCount, FWD ? 0 : 1);
    drainAndClear();

    // Flush and hazard together: the squashed writer r9 must leave one bubble.
    issue(1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1);
    #1 step();
    issue(1'b0, 4'd2, 4'd0, 4'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1 check("flush_hazard", hazard, 1);
    step();
    flush = 1'b0;
    issue(1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 check("single_bubble", hazard, 0);
    check("flush_hazard_count", stallCount, 1);
    drainAndClear();

    // Continuous r15 -> r15 load chain: repeated stalls saturate the counter.
    issue(1'b0, 4'd15, 4'd0, 4'd15, 1'b1, 1'b1);
    repeat (40) step();
    check("sat_count", stallCount, 15);

    // Clear while a stall is in progress. The clear must win over the count.
    begin
      int budget = 10;
      while (!hazard && budget > 0) begin
        step();
        budget--;
      end
      check("stall_found", hazard, 1);
    end
    clrStats = 1'b1;
    step();
    clrStats = 1'b0;
    check("clr_in_stall", stallCount, 0);
    idle();
    repeat (3) step();
    check("drain_count", stallCount, 0);

    // Counting resumes after the clear; R15 also matches through Rm.
    issue(1'b0, 4'd0, 4'd0, 4'd15, 1'b1, 1'b1);
    #1 step();
    issue(1'b1, 4'd0, 4'd15, 4'd0, 1'b0, 1'b0);
    #1 check("r15_rdm", hazard, 1);
    step();
    step();
    check("resume_hazard", hazard, 0);
    check("resume_count", stallCount, FWD ? 1 : 2);
    idle();
    step();
    step();

    // Asynchronous reset in the middle of a stall.
    issue(1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1);
    #1 step();
    issue(1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 check("rst_pre", hazard, 1);
    rst = 1'b1;
    #1 check("rst_hazard", hazard, 0);
    check("rst_count", stallCount, 0);
    rst = 1'b0;
    #1 check("rst_release", hazard, 0);
    step();
    check("rst_post", hazard, 0);
    check("rst_post_count", stallCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
